parity_frame_checker: RTL

- Streaming parity checker for multi-word frames of DATA_W-bit words.
- Per word, XOR-reduces a selectable bit group and accumulates it across the frame.
- At frame end, compares the accumulated parity plus a received parity bit against the requested even/odd sense.
- Reports the result through a valid/ready output and keeps a saturating error count. Sits after a link receiver, ahead of frame consumers.

---
 rtl/parity_pkg.sv | 35 +++
 rtl/parity_group_reduce.sv | 18 +
 rtl/parity_frame_checker.sv | 125 ++++++++++++
 3 files changed

// File: rtl/parity_pkg.sv
// Shared types and helpers for the parity frame checker and generator.
// The group mask is built at the maximum width so that any DATA_W up to MAX_W can slice it.
package parity_pkg;
    localparam int MAX_W = 64;

    typedef enum logic [1:0] {
        GRP_UPPER    = 2'd0,
        GRP_EVEN_IDX = 2'd1,
        GRP_ODD_IDX  = 2'd2,
        GRP_ALL      = 2'd3
    } grp_e;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACC    = 2'd1,
        REPORT = 2'd2
    } state_e;

    // Bits at or above w are always zero, so narrower words see only their own lanes.
    function automatic logic [MAX_W-1:0] group_mask(grp_e g, int w);
        logic [MAX_W-1:0] m;
        m = '0;
        for (int i = 0; i < MAX_W; i++) begin
            if (i < w) begin
                unique case (g)
                    GRP_UPPER:    m[i] = (i >= w / 2);
                    GRP_EVEN_IDX: m[i] = (i % 2 == 0);
                    GRP_ODD_IDX:  m[i] = (i % 2 == 1);
                    default:      m[i] = 1'b1;
                endcase
            end
        end
        return m;
    endfunction
endpackage

// File: rtl/parity_group_reduce.sv
// Combinational XOR reduction of the bit group selected by chk_i.
// Shared with the parity generator, so it carries no state.
module parity_group_reduce
    import parity_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic [DATA_W-1:0] data_i,
    input  logic [1:0]        chk_i,
    output logic              p_w_o
);
    logic [MAX_W-1:0] mask;
    logic [MAX_W-1:0] data_ext;

    assign mask     = group_mask(grp_e'(chk_i), DATA_W);
    assign data_ext = MAX_W'(data_i);
    assign p_w_o    = ^(data_ext & mask);
endmodule

// File: rtl/parity_frame_checker.sv
// Streaming frame parity checker: accumulates group parity per frame, reports the
// result through a valid/ready port and keeps a saturating failed-frame count.
module parity_frame_checker
    import parity_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    input  logic              par_in,
    input  logic [1:0]        chk,
    input  logic              even,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_ok,
    output logic              out_parity,
    input  logic              err_clr,
    output logic [CNT_W-1:0]  err_cnt,
    output logic              busy
);
    state_e             state_q, state_d;
    logic               acc_q, acc_d;
    logic [1:0]         chk_q, chk_d;
    logic               even_q, even_d;
    logic               ok_q, ok_d;
    logic [CNT_W-1:0]   err_cnt_q, err_cnt_d;

    logic               in_idle, p_w, acc_next, ok_next, inc;
    logic [1:0]         chk_sel;
    logic               even_sel;

    // The first beat of a frame uses the live mode inputs; later beats use the latched copy.
    assign in_idle  = (state_q == IDLE);
    assign chk_sel  = in_idle ? chk : chk_q;
    assign even_sel = in_idle ? even : even_q;

    parity_group_reduce #(.DATA_W(DATA_W)) u_reduce (
        .data_i (in_data),
        .chk_i  (chk_sel),
        .p_w_o  (p_w)
    );

    assign acc_next = (in_idle ? 1'b0 : acc_q) ^ p_w;
    assign ok_next  = ((acc_next ^ par_in) == ~even_sel);
    assign inc      = in_valid && in_ready && in_last && !ok_next;

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        chk_d     = chk_q;
        even_d    = even_q;
        ok_d      = ok_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        unique case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    chk_d  = chk;
                    even_d = even;
                    acc_d  = acc_next;
                    if (in_last) begin
                        ok_d    = ok_next;
                        state_d = REPORT;
                    end else begin
                        state_d = ACC;
                    end
                end
            end
            ACC: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    acc_d = acc_next;
                    if (in_last) begin
                        ok_d    = ok_next;
                        state_d = REPORT;
                    end
                end
            end
            REPORT: begin
                out_valid = 1'b1;
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Clear takes priority, but a failure in the same cycle still counts as one.
    always_comb begin
        err_cnt_d = err_cnt_q;
        if (err_clr) begin
            err_cnt_d = inc ? CNT_W'(1) : '0;
        end else if (inc && (err_cnt_q != {CNT_W{1'b1}})) begin
            err_cnt_d = err_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            acc_q     <= 1'b0;
            chk_q     <= 2'd0;
            even_q    <= 1'b0;
            ok_q      <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            chk_q     <= chk_d;
            even_q    <= even_d;
            ok_q      <= ok_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign out_ok     = ok_q;
    assign out_parity = acc_q;
    assign err_cnt    = err_cnt_q;
    assign busy       = !in_idle;
endmodule
